// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the ID/EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             read_req;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall_req;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, read_req, cancel,
    input  hi, lo, busy, stall_req, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, read_req, cancel,
    output hi, lo, busy, stall_req, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit with HI/LO registers: multi-cycle
// multiply, restoring divide (one quotient bit per cycle) and MTHI/MTLO.
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic          Clk,
  input logic          Reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CMAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] op_a, op_b, rem;
  logic             mul_signed, neg_q, neg_r, div_zero, done;

  logic             accept, busy, mul_fin, fix_fin, div_step;

  // ---------------- state register ----------------
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start && !bus.cancel && (bus.op <= OP_MTLO);
        if (accept && (bus.op == OP_MULT || bus.op == OP_MULTU)) state_nx = MUL;
        if (accept && (bus.op == OP_DIV  || bus.op == OP_DIVU))  state_nx = DIV;
      end
      MUL:     if (bus.cancel || count == '0) state_nx = IDLE;
      DIV:     if (bus.cancel) state_nx = IDLE;
               else if (count == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- output / control decode ----------------
  always_comb begin
    busy          = (state != IDLE);
    mul_fin       = (state == MUL) && (count == '0) && !bus.cancel;
    fix_fin       = (state == FIX) && !bus.cancel;
    div_step      = (state == DIV) && !bus.cancel;
    bus.busy      = busy;
    bus.stall_req = busy && (bus.start || bus.read_req);
    bus.hi        = hi;
    bus.lo        = lo;
    bus.done      = done;
  end

  // ---------------- datapath ----------------
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] quot_fixed, rem_fixed;

  always_comb begin
    rs_neg    = (bus.op == OP_DIV) && bus.rs_val[WIDTH-1];
    rt_neg    = (bus.op == OP_DIV) && bus.rt_val[WIDTH-1];
    abs_rs    = rs_neg ? -bus.rs_val : bus.rs_val;
    abs_rt    = rt_neg ? -bus.rt_val : bus.rt_val;
    ext_a     = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b     = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    product   = ext_a * ext_b;
    rem_shift = {rem, op_a[WIDTH-1]};
    diff      = rem_shift - {1'b0, op_b};
    // A zero divisor already leaves |rs| in the remainder, so only the
    // quotient needs forcing; its sign must not be applied.
    quot_fixed = div_zero ? '1 : (neg_q ? -op_a : op_a);
    rem_fixed  = neg_r ? -rem : rem;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi         <= '0;
      lo         <= '0;
      count      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= mul_fin || fix_fin;
      if (accept) begin
        case (bus.op)
          OP_MULT, OP_MULTU: begin
            op_a       <= bus.rs_val;
            op_b       <= bus.rt_val;
            mul_signed <= (bus.op == OP_MULT);
            count      <= CW'(MUL_LATENCY - 1);
          end
          OP_DIV, OP_DIVU: begin
            op_a     <= abs_rs;
            op_b     <= abs_rt;
            rem      <= '0;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (bus.rt_val == '0);
            count    <= CW'(WIDTH - 1);
          end
          OP_MTHI: hi <= bus.rs_val;
          OP_MTLO: lo <= bus.rs_val;
          default: ;
        endcase
      end
      if (state == MUL && count != '0) count <= count - CW'(1);
      if (div_step) begin
        // op_a doubles as the shifting dividend / quotient register
        if (!diff[WIDTH]) begin
          rem  <= diff[WIDTH-1:0];
          op_a <= {op_a[WIDTH-2:0], 1'b1};
        end else begin
          rem  <= rem_shift[WIDTH-1:0];
          op_a <= {op_a[WIDTH-2:0], 1'b0};
        end
        if (count != '0) count <= count - CW'(1);
      end
      if (mul_fin) {hi, lo} <= product;
      if (fix_fin) begin
        hi <= rem_fixed;
        lo <= quot_fixed;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .MUL_LATENCY(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present an op for one cycle (cycle N); returns positioned in N+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Number of cycles from N+1 until done is seen; capped at 100.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  int cyc;
  int pulses;

  initial begin
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.read_req = 0; bus.cancel = 0;
    Reset = 1;
    tick(); tick();
    Reset = 0;
    bus.read_req = 1;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    bus.read_req = 0;

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy1", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check("mult_lat", 64'(cyc), 64'd2);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);
    check("mult_busy_done", 64'(bus.busy), 64'd0);

    // MULTU same operands
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc);
    check("multu_lat", 64'(cyc), 64'd2);
    check("multu_hi", 64'(bus.hi), 64'h2);
    check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    check("div_lat", 64'(cyc), 64'd33);
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    tick();
    check("done_pulse", 64'(bus.done), 64'd0);

    // DIVU 100 / 7
    issue(3'd3, 32'd100, 32'd7);
    wait_done(cyc);
    check("divu_lo", 64'(bus.lo), 64'd14);
    check("divu_hi", 64'(bus.hi), 64'd2);

    // DIV by zero, positive and negative dividend
    issue(3'd2, 32'h1234, 32'd0);
    wait_done(cyc);
    check("dz_lat", 64'(cyc), 64'd33);
    check("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("dz_hi", 64'(bus.hi), 64'h1234);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc);
    check("dzn_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("dzn_hi", 64'(bus.hi), 64'hFFFF_FFFB);

    // Signed overflow
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    check("ovf_hi", 64'(bus.hi), 64'd0);

    // Stall while busy; held MULTU accepted in done cycle
    issue(3'd3, 32'd100, 32'd7);
    bus.start = 1; bus.op = 3'd1; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    bus.read_req = 1;
    #1;
    pulses = 0;
    while (!bus.done && pulses < 100) begin
      check("stall_busy", 64'(bus.stall_req), 64'd1);
      tick();
      pulses++;
    end
    check("stall_cycles", 64'(pulses), 64'd33);
    check("stall_done", 64'(bus.stall_req), 64'd0);
    check("stall_lo", 64'(bus.lo), 64'd14);
    tick();
    bus.start = 0; bus.read_req = 0;
    check("second_accepted", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check("second_lat", 64'(cyc), 64'd2);
    check("second_lo", 64'(bus.lo), 64'd15);
    check("second_hi", 64'(bus.hi), 64'd0);

    // Cancel mid-DIV
    issue(3'd4, 32'hA, 32'd0);
    check("mthi", 64'(bus.hi), 64'hA);
    issue(3'd5, 32'hB, 32'd0);
    issue(3'd2, 32'd1000, 32'd3);
    tick(); tick(); tick(); tick();
    bus.cancel = 1;
    tick();
    bus.cancel = 0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) pulses++;
      tick();
    end
    check("cancel_nodone", 64'(pulses), 64'd0);
    check("cancel_hi", 64'(bus.hi), 64'hA);
    check("cancel_lo", 64'(bus.lo), 64'hB);

    // cancel together with start in IDLE, and ignored op code
    bus.cancel = 1;
    issue(3'd0, 32'd2, 32'd2);
    bus.cancel = 0;
    check("cancel_start", 64'(bus.busy), 64'd0);
    issue(3'd6, 32'h77, 32'h77);
    check("op6_busy", 64'(bus.busy), 64'd0);
    check("op6_hi", 64'(bus.hi), 64'hA);

    // MTLO while idle
    issue(3'd5, 32'h55, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'h55);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_done", 64'(bus.done), 64'd0);

    // Reset mid-DIV at N+10
    issue(3'd2, 32'd50, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    Reset = 1;
    tick();
    Reset = 0;
    check("rmid_busy", 64'(bus.busy), 64'd0);
    check("rmid_hi", 64'(bus.hi), 64'd0);
    check("rmid_lo", 64'(bus.lo), 64'd0);
    check("rmid_done", 64'(bus.done), 64'd0);
    issue(3'd1, 32'd3, 32'd5);
    wait_done(cyc);
    check("rmid_mul_lat", 64'(cyc), 64'd2);
    check("rmid_mul_lo", 64'(bus.lo), 64'd15);
    check("rmid_mul_hi", 64'(bus.hi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
